// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD add/subtract datapath.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add/subtract cell; subtraction uses the nine's complement of b plus carry-in.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  logic       sub,
    output bcd_digit_t digit,
    output logic       cout
);

    bcd_digit_t b_eff;
    logic [4:0] s;
    logic [4:0] s_corr;

    always_comb begin
        b_eff  = sub ? 4'(BCD_MAX - b) : b;
        s      = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
        s_corr = s + {1'b0, BCD_CORR};
        if (s > {1'b0, BCD_MAX}) begin
            digit = s_corr[3:0];
            cout  = 1'b1;
        end else begin
            digit = s[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | shifting one digit per edge through bcd_digit_add
// DONE  | result held until out_ready (out_valid=1)
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_sh;
    logic [W-1:0]  res_next;
    logic          sub_q;
    logic          c_run;
    logic [IW-1:0] idx;
    logic          op_bad;
    bcd_digit_t    dig;
    logic          dig_cout;

    bcd_digit_add u_digit (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .cin   (c_run),
        .sub   (sub_q),
        .digit (dig),
        .cout  (dig_cout)
    );

    always_comb begin
        op_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX)
                op_bad = 1'b1;
        end
    end

    // New digit enters at the top so digit 0 ends up in bits [3:0] after DIGITS shifts.
    always_comb begin
        res_next          = res_sh >> 4;
        res_next[W-1 -: 4] = dig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            sub_q   <= 1'b0;
            c_run   <= 1'b0;
            idx     <= '0;
            carry   <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        sub_q   <= sub;
                        c_run   <= sub;
                        idx     <= '0;
                        invalid <= op_bad;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    res_sh <= res_next;
                    c_run  <= dig_cout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        carry <= dig_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_sh;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomized self-checking bench for bcd_serial_addsub (DIGITS=4) against a decimal reference model.
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         invalid;

    int total = 0;
    int bad   = 0;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--)
            r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Legal operands use plain decimal arithmetic; illegal digits fall back to the per-digit rule.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                         output logic [W-1:0] r, output logic c, output logic inv);
        int ai, bi, sum, mod;
        int ad, bd, dsum, cc;
        mod = 1;
        for (int i = 0; i < DIGITS; i++) mod = mod * 10;
        inv = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (av[4*i +: 4] > 9 || bv[4*i +: 4] > 9) inv = 1'b1;
        if (!inv) begin
            ai = bcd_to_int(av);
            bi = bcd_to_int(bv);
            if (!s) begin
                sum = ai + bi;
                c   = (sum >= mod);
                r   = int_to_bcd(sum % mod);
            end else begin
                c = (ai >= bi);
                r = int_to_bcd((ai - bi + mod) % mod);
            end
        end else begin
            cc = s ? 1 : 0;
            r  = '0;
            for (int i = 0; i < DIGITS; i++) begin
                ad = int'(av[4*i +: 4]);
                bd = int'(bv[4*i +: 4]);
                if (s) bd = (9 - bd) & 15;
                dsum = ad + bd + cc;
                if (dsum > 9) begin
                    r[4*i +: 4] = 4'((dsum + 6) & 15);
                    cc = 1;
                end else begin
                    r[4*i +: 4] = 4'(dsum);
                    cc = 0;
                end
            end
            c = cc[0];
        end
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Drives one operation from IDLE through DONE and release, checking timing and values.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                         input int hold, input string tag);
        logic [W-1:0] er;
        logic ec, ei;
        int lat;
        model(av, bv, s, er, ec, ei);
        @(negedge clk);
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        sub = s;
        @(negedge clk);
        in_valid = 1'b1;
        a = $urandom();
        b = $urandom();
        sub = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            out_ready = $urandom_range(0, 1);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        check({tag, ".lat"}, 32'(lat), 32'(DIGITS));
        check({tag, ".res"}, 32'(result), 32'(er));
        check({tag, ".cy"}, 32'(carry), 32'(ec));
        check({tag, ".inv"}, 32'(invalid), 32'(ei));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_res"}, 32'(result), 32'(er));
            check({tag, ".hold_rdy"}, 32'({in_ready, out_valid}), 32'b01);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".rel"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int lat;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst.state", 32'({in_ready, out_valid}), 32'b10);
        check("rst.res", 32'(result), 32'd0);
        check("rst.flags", 32'({carry, invalid}), 32'd0);

        do_op(16'h1234, 16'h8766, 1'b0, 0, "add_wrap");
        do_op(16'h9999, 16'h9999, 1'b0, 1, "add_max");
        do_op(16'h5000, 16'h0001, 1'b1, 0, "sub_pos");
        do_op(16'h0001, 16'h0002, 1'b1, 0, "sub_neg");
        do_op(16'h4321, 16'h1111, 1'b0, 5, "hold5");
        do_op(16'h00A0, 16'h0000, 1'b0, 0, "inv_digit");

        // Reset lands on the second RUN edge: the operation must vanish.
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run.state", 32'({in_ready, out_valid}), 32'b10);
        check("rst_run.res", 32'(result), 32'd0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("rst_run.no_valid", 32'(lat), 32'd0);
        do_op(16'h0005, 16'h0005, 1'b0, 0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the operand width in BCD digits (legal range 1..16).
REQ-002 clk  in  1  the only clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  an operand pair is offered.
REQ-005 in_ready  out  1  the block can accept an operand pair.
REQ-006 a  in  4*DIGITS  BCD operand A; digit 0 is bits [3:0] (least significant).
REQ-007 b  in  4*DIGITS  BCD operand B, same packing as a.
REQ-008 sub  in  1  0 = A+B, 1 = A-B; sampled with the operands.
REQ-009 out_valid  out  1  result, carry and invalid are valid.
REQ-010 out_ready  in  1  the consumer takes the result.
REQ-011 result  out  4*DIGITS  BCD result, same packing as a.
REQ-012 carry  out  1  for add, the decimal carry out; for sub, 1 = no borrow (A>=B) and 0 = negative.
REQ-013 invalid  out  1  at least one latched operand digit was greater than 9.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-016 An accept SHALL occur on an edge where in_valid=1 and in_ready=1.
  - a, b and sub latched.
  - digit index cleared to 0.
  - carry-in set to sub.
  - invalid flag loaded from the operand digit check.
  - state goes to RUN.
REQ-017 In RUN, each edge SHALL process one digit, least-significant first, using the digit rule:
  - b' = b_i for add; b' = (9 - b_i) mod 16 for sub.
  - s = a_i + b' + c, 5 bits wide.
  - if s > 9: digit = (s+6)[3:0] and c_next = 1; otherwise digit = s[3:0] and c_next = 0.
REQ-018 The edge that processes digit DIGITS-1 SHALL move the state to DONE and latch the final c_next as carry.
REQ-019 out_valid SHALL rise exactly DIGITS edges after the accepting edge.
REQ-020 For sub with carry=0, result SHALL be the ten's complement, i.e. (A-B) mod 10^DIGITS.
REQ-021 In DONE, result, carry and invalid SHALL hold stable until an edge where out_ready=1; that edge moves the state to IDLE.
REQ-022 A new accept SHALL NOT happen on the same edge that leaves DONE; minimum spacing between accepts is DIGITS+2 edges.
REQ-023 in_valid, a, b and sub SHALL be ignored outside IDLE.
REQ-024 An invalid operand digit SHALL NOT stall or abort the operation.
  - invalid=1.
  - result follows the digit rule exactly, for deterministic checking.
REQ-025 out_ready SHALL be ignored outside DONE.

Reset
REQ-026 While rst=1 at an edge, the block SHALL load these values:
  - state = IDLE, so in_ready=1 and out_valid=0.
  - result=0, carry=0, invalid=0, digit index=0.
REQ-027 rst SHALL take priority over every other event.
REQ-028 A reset during RUN or DONE SHALL drop the operation with no output; the block accepts again on the first edge after rst falls.

Structure
REQ-029 Shared package bcd_pkg SHALL hold:
  - the state enum.
  - constants BCD_MAX=9 and BCD_CORR=6.
  - a 4-bit BCD digit typedef.
REQ-030 The digit rule SHALL be a combinational sub-module bcd_digit_add, with ports a, b, cin, sub, digit and cout.
REQ-031 Operand and result storage SHALL be shift registers moving 4 bits per RUN edge; there SHALL be no DIGITS-wide parallel adder.

Verification
REQ-032 The bench SHALL run all scenarios with DIGITS=4 and SHALL cover:
  - add 1234 + 8766 -> result 0000, carry 1, invalid 0, out_valid 4 edges after accept.
  - add 9999 + 9999 -> result 9998, carry 1.
  - sub 5000 - 0001 -> result 4999, carry 1; sub 0001 - 0002 -> result 9999, carry 0.
  - out_ready held low 5 cycles in DONE -> result stable and in_ready 0 throughout; the release edge gives in_ready=1 on the next cycle.
  - rst pulsed on the 2nd RUN edge -> out_valid never rises, in_ready=1 after reset, the next op 0005+0005 gives 0010, carry 0.
  - a=00A0, b=0000, add -> invalid 1, result equals the digit-rule model output.
